// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU: sequencer states, default widths
// and opcode encodings.
package cpu_pkg;

  localparam int PC_W_DEF   = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_BR  = 3'd3;
  localparam logic [2:0] OP_LD  = 3'd4;
  localparam logic [2:0] OP_ST  = 3'd5;
  localparam logic [2:0] OP_LDC = 3'd6;
  localparam logic [2:0] OP_LDH = 3'd7;

endpackage

// File: rtl/cpu_pc_reg.sv
// Program counter: load has priority over increment; increment wraps modulo 2^PC_W.
module cpu_pc_reg #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [PC_W-1:0] load_val,
  output logic [PC_W-1:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    pc <= '0;
    else if (load) pc <= load_val;
    else if (inc)  pc <= pc + PC_W'(1);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Fetch/decode/execute sequencer owning PC, IR and MDR and mastering the memory port.
// Optional build macro CPU_SEQ_SINGLE_STEP_EN adds a 'step' input for single-stepping.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CPU_SEQ_SINGLE_STEP_EN
  input  logic              step,
`endif
  input  logic              run,
  output logic              mem_req,
  output logic              mem_we,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  input  logic [PC_W-1:0]   data_addr,
  output logic [2:0]        opcode,
  output logic [DATA_W-1:0] ir,
  input  logic              dec_branch,
  input  logic              dec_rd_ram,
  input  logic              dec_w_ram,
  input  logic              dec_w_reg,
  input  logic              br_take,
  input  logic [PC_W-1:0]   br_target,
  output logic [DATA_W-1:0] mdr,
  output logic              reg_we,
  output logic [PC_W-1:0]   pc,
  output logic              instr_done
);

  state_t state, state_n;
  logic   fetch_en, fetch_req, fetch_busy, fetch_acc;
  logic   mem_wr_q, pc_load;

`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic step_q, step_pend, step_edge;

  assign step_edge = step & ~step_q;
  assign fetch_en  = run | step_pend | step_edge;

  // A step edge stays pending until a fetch is accepted; an edge landing on the
  // accept cycle of an earlier pending step is kept for the next instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q    <= 1'b0;
      step_pend <= 1'b0;
    end else begin
      step_q    <= step;
      step_pend <= fetch_acc ? (step_pend & step_edge) : (step_pend | step_edge);
    end
  end
`else
  assign fetch_en = run;
`endif

  // Once a fetch request is out it is held until ack, even if run drops.
  // Gating with rst_n keeps the port quiet while reset is asserted.
  assign fetch_req = rst_n & (state == ST_FETCH) & (fetch_en | fetch_busy);
  assign fetch_acc = fetch_req & mem_ack;
  assign pc_load   = (state == ST_EXEC) & dec_branch & br_take;
  assign opcode    = ir[DATA_W-1 -: 3];

  cpu_pc_reg #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (fetch_acc),
    .load     (pc_load),
    .load_val (br_target),
    .pc       (pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_FETCH;
    else        state <= state_n;
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_n = state;
    unique case (state)
      ST_FETCH:  if (fetch_acc) state_n = ST_DECODE;
      ST_DECODE: state_n = ST_EXEC;
      ST_EXEC: begin
        if (dec_branch)                    state_n = ST_FETCH;
        else if (dec_rd_ram || dec_w_ram)  state_n = ST_MEM;
        else if (dec_w_reg)                state_n = ST_WB;
        else                               state_n = ST_FETCH;
      end
      ST_MEM:    if (mem_ack) state_n = mem_wr_q ? ST_FETCH : ST_WB;
      ST_WB:     state_n = ST_FETCH;
      default:   state_n = ST_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = pc;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    unique case (state)
      ST_FETCH: mem_req = fetch_req;
      ST_EXEC:  instr_done = dec_branch | ~(dec_rd_ram | dec_w_ram | dec_w_reg);
      ST_MEM: begin
        mem_req    = 1'b1;
        mem_we     = mem_wr_q;
        mem_addr   = data_addr;
        instr_done = mem_ack & mem_wr_q;
      end
      ST_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  // A simultaneous read+write strobe is resolved as a read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir         <= '0;
      mdr        <= '0;
      mem_wr_q   <= 1'b0;
      fetch_busy <= 1'b0;
    end else begin
      fetch_busy <= fetch_req & ~mem_ack;
      if (fetch_acc) ir <= mem_rdata;
      if (state == ST_EXEC && state_n == ST_MEM) mem_wr_q <= dec_w_ram & ~dec_rd_ram;
      if (state == ST_MEM && mem_ack && !mem_wr_q) mdr <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: table of instructions run through a bench
// memory/decoder model, scoreboarded per retirement, plus reset/run/step sequences.
module tb_cpu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run;
  logic       mem_req, mem_we;
  logic [7:0] mem_addr, mem_rdata;
  logic       mem_ack;
  logic [7:0] data_addr;
  logic [2:0] opcode;
  logic [7:0] ir;
  logic       dec_branch, dec_rd_ram, dec_w_ram, dec_w_reg;
  logic       br_take;
  logic [7:0] br_target;
  logic [7:0] mdr;
  logic       reg_we;
  logic [7:0] pc;
  logic       instr_done;
`ifdef CPU_SEQ_SINGLE_STEP_EN
  logic       step = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CPU_SEQ_SINGLE_STEP_EN
    .step       (step),
`endif
    .run        (run),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .data_addr  (data_addr),
    .opcode     (opcode),
    .ir         (ir),
    .dec_branch (dec_branch),
    .dec_rd_ram (dec_rd_ram),
    .dec_w_ram  (dec_w_ram),
    .dec_w_reg  (dec_w_reg),
    .br_take    (br_take),
    .br_target  (br_target),
    .mdr        (mdr),
    .reg_we     (reg_we),
    .pc         (pc),
    .instr_done (instr_done)
  );

  typedef struct {
    logic [7:0] instr;
    logic       br, rd, wr, wreg, take;
    logic [7:0] target, ld_data;
    int         fetch_wait, mem_wait, exp_cycles, exp_rwe;
    logic       exp_we;
    logic [7:0] exp_daddr;
  } vec_t;

  typedef struct {
    logic [7:0] pc, ir, mdr;
    int         cycles, rwe;
    logic       we;
    logic [7:0] daddr;
  } exp_t;

  vec_t       vecs[12];
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] pc_model = 8'h00;
  logic [7:0] mdr_model = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Runs one instruction from the current FETCH state, acting as memory and decoder.
  task automatic run_vec(input int idx, input vec_t v);
    exp_t       e, got;
    int         cyc, phase, waitc, w;
    logic       done, ok;
    logic [7:0] ir_prev;

    dec_branch = v.br; dec_rd_ram = v.rd; dec_w_ram = v.wr; dec_w_reg = v.wreg;
    br_take = v.take; br_target = v.target; data_addr = 8'h80;
    e.pc     = (v.br && v.take) ? v.target : pc_model + 8'h01;
    e.ir     = v.instr;
    e.mdr    = (!v.br && v.rd) ? v.ld_data : mdr_model;
    e.cycles = v.exp_cycles;
    e.rwe    = v.exp_rwe;
    e.we     = v.exp_we;
    e.daddr  = v.exp_daddr;
    sb.push_back(e);

    got.rwe = 0; got.we = 1'b0; got.daddr = 8'hEE;
    cyc = 0; phase = 0; waitc = 0; done = 1'b0; ok = 1'b1; ir_prev = ir;
    #1;
    while (!done && cyc < 60) begin
      mem_ack = 1'b0;
      if (mem_req) begin
        if (phase == 0 && mem_addr !== pc_model) ok = 1'b0;
        if (phase == 0 && ir !== ir_prev) ok = 1'b0;
        if (phase == 1 && mem_addr !== 8'h80) ok = 1'b0;
        w = (phase == 0) ? v.fetch_wait : v.mem_wait;
        if (waitc == w) begin
          mem_ack   = 1'b1;
          mem_rdata = (phase == 0) ? v.instr : v.ld_data;
          if (phase == 1) begin
            got.daddr = mem_addr;
            got.we    = mem_we;
          end
          phase++;
          waitc = 0;
        end else begin
          waitc++;
        end
      end
      #1;
      if (reg_we && !instr_done) ok = 1'b0;
      if (reg_we) got.rwe++;
      if (instr_done) done = 1'b1;
      cyc++;
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    mem_ack = 1'b0;
    check($sformatf("v%0d_retired", idx), {31'd0, done}, 32'd1);
    e = sb.pop_front();
    check($sformatf("v%0d_pc", idx), {24'd0, pc}, {24'd0, e.pc});
    check($sformatf("v%0d_ir", idx), {24'd0, ir}, {24'd0, e.ir});
    check($sformatf("v%0d_mdr", idx), {24'd0, mdr}, {24'd0, e.mdr});
    check($sformatf("v%0d_cycles", idx), cyc, e.cycles);
    check($sformatf("v%0d_reg_we", idx), got.rwe, e.rwe);
    check($sformatf("v%0d_mem_we", idx), {31'd0, got.we}, {31'd0, e.we});
    check($sformatf("v%0d_data_addr", idx), {24'd0, got.daddr}, {24'd0, e.daddr});
    check($sformatf("v%0d_protocol", idx), {31'd0, ok}, 32'd1);
    pc_model  = e.pc;
    mdr_model = e.mdr;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            instr  br rd wr wr tk target  ld     fw mw cyc rwe we  daddr
    vecs[0]  = '{8'h00, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 4, 1, 0, 8'hEE}; // ADD
    vecs[1]  = '{8'h25, 0, 0, 0, 1, 0, 8'h00, 8'h00, 3, 0, 7, 1, 0, 8'hEE}; // SUB, slow fetch
    vecs[2]  = '{8'h60, 1, 0, 0, 0, 1, 8'h40, 8'h00, 0, 0, 3, 0, 0, 8'hEE}; // BR taken
    vecs[3]  = '{8'h63, 1, 0, 0, 1, 0, 8'h77, 8'h00, 0, 0, 3, 0, 0, 8'hEE}; // BR not taken
    vecs[4]  = '{8'h80, 0, 1, 0, 0, 0, 8'h00, 8'hA5, 0, 0, 5, 1, 0, 8'h80}; // LD
    vecs[5]  = '{8'hA0, 0, 0, 1, 0, 0, 8'h00, 8'h11, 0, 0, 4, 0, 1, 8'h80}; // ST
    vecs[6]  = '{8'h81, 0, 1, 1, 0, 0, 8'h00, 8'h3C, 0, 0, 5, 1, 0, 8'h80}; // rd+wr -> read
    vecs[7]  = '{8'hC0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 3, 0, 0, 8'hEE}; // no-op
    vecs[8]  = '{8'h82, 0, 1, 0, 0, 0, 8'h00, 8'h5A, 0, 2, 7, 1, 0, 8'h80}; // LD, slow mem
    vecs[9]  = '{8'h61, 1, 0, 0, 0, 1, 8'hFF, 8'h00, 0, 0, 3, 0, 0, 8'hEE}; // BR to FF
    vecs[10] = '{8'h40, 0, 0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 4, 1, 0, 8'hEE}; // AND at FF, wraps
    vecs[11] = '{8'h62, 1, 1, 0, 0, 0, 8'h10, 8'h00, 0, 0, 3, 0, 0, 8'hEE}; // BR beats memory

    run = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00; data_addr = 8'h80;
    dec_branch = 1'b0; dec_rd_ram = 1'b0; dec_w_ram = 1'b0; dec_w_reg = 1'b0;
    br_take = 1'b0; br_target = 8'h00;
    rst_n = 1'b0;
    #13;
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_pc", {24'd0, pc}, 32'd0);
    check("rst_ir", {24'd0, ir}, 32'd0);
    check("rst_mdr", {24'd0, mdr}, 32'd0);
    check("rst_reg_we", {31'd0, reg_we}, 32'd0);
    check("rst_instr_done", {31'd0, instr_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);
    check("sb_empty", sb.size(), 0);

    // Reset while a load waits in MEM: access dropped at once, late ack ignored.
    dec_branch = 1'b0; dec_rd_ram = 1'b1; dec_w_ram = 1'b0; dec_w_reg = 1'b0; br_take = 1'b0;
    mem_ack = 1'b1; mem_rdata = 8'h80;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    #1;
    check("mem_wait_req", {31'd0, mem_req}, 32'd1);
    check("mem_wait_addr", {24'd0, mem_addr}, 32'h80);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    check("midrst_pc", {24'd0, pc}, 32'd0);
    check("midrst_mdr", {24'd0, mdr}, 32'd0);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'hC3;
    @(posedge clk); @(negedge clk);
    mem_ack = 1'b0;
    #1;
    check("late_ack_ir", {24'd0, ir}, 32'd0);
    check("late_ack_mdr", {24'd0, mdr}, 32'd0);
    check("late_ack_pc", {24'd0, pc}, 32'd0);

    // run=0 holds FETCH with no request.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) n++;
      @(posedge clk); @(negedge clk);
    end
    check("run0_no_req", n, 0);

`ifdef CPU_SEQ_SINGLE_STEP_EN
    // Two step edges while run=0 retire exactly two ALU instructions.
    dec_rd_ram = 1'b0; dec_w_reg = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      step = (i == 3 || i == 4 || i == 20);
      #1;
      mem_ack = mem_req;
      mem_rdata = 8'h00;
      #1;
      if (instr_done) n++;
      @(posedge clk); @(negedge clk);
    end
    mem_ack = 1'b0;
    check("step_two_instrs", n, 2);
    check("step_pc", {24'd0, pc}, 32'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
- Owns the program counter (PC) and the instruction register (IR). Drives the shared memory port with a req/ack handshake.
- Presents IR opcode bits to the instruction decoder, then consumes the decoded strobes to choose the execute path.
- Sits between the memory and the decoder/register file. It is the only master of the memory port.

Parameters:
- PC_W, 8, program counter and memory address width.
- DATA_W, 8, instruction and data word width; opcode is IR[DATA_W-1:DATA_W-3].

Ports:
- clk  in  1  system clock, all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  1 = fetch allowed; 0 = hold in FETCH with mem_req=0.
- mem_req  out  1  memory access request, held until ack.
- mem_we  out  1  1 = write access (only in MEM state).
- mem_addr  out  PC_W  PC in FETCH, data_addr in MEM.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete this cycle.
- data_addr  in  PC_W  operand address from the datapath.
- opcode  out  3  IR[DATA_W-1:DATA_W-3] to the decoder.
- ir  out  DATA_W  instruction register.
- dec_branch, dec_rd_ram, dec_w_ram, dec_w_reg  in  1 each  decoder strobes, sampled in EXEC.
- br_take  in  1  branch condition from the datapath.
- br_target  in  PC_W  branch destination.
- mdr  out  DATA_W  memory data register (load result).
- reg_we  out  1  one-cycle register-file write pulse.
- pc  out  PC_W  program counter.
- instr_done  out  1  one-cycle pulse when an instruction retires.

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH; pc=0, ir=0, mdr=0.
  - mem_req, mem_we, reg_we and instr_done all 0.
  - Reset asserted mid-access abandons the access immediately; a later mem_ack is ignored.
- States: FETCH, DECODE, EXEC, MEM, WB. Binary-encoded, 3 bits.
- FETCH:
  - mem_req=run, mem_we=0, mem_addr=pc.
  - On mem_ack & run: ir<=mem_rdata; pc<=pc+1 (wraps at 2^PC_W-1 to 0); go to DECODE.
  - mem_ack while mem_req=0 is ignored.
- DECODE: exactly one cycle so the decoder output settles from opcode; then go to EXEC.
- EXEC: one cycle; priority branch > memory > register write.
  - dec_branch: if br_take, pc<=br_target; instr_done=1; go to FETCH.
  - Otherwise, dec_rd_ram|dec_w_ram: go to MEM.
  - Otherwise, dec_w_reg: go to WB.
  - Otherwise: instr_done=1; go to FETCH.
  - dec_rd_ram and dec_w_ram both 1 is treated as a read; mem_we=0.
- MEM:
  - mem_req=1, mem_we=latched dec_w_ram (and not a read), mem_addr=data_addr.
  - Decoder strobes are latched on the EXEC→MEM transition.
  - Wait indefinitely for mem_ack; run is ignored.
  - On ack, read: mdr<=mem_rdata; go to WB.
  - On ack, write: instr_done=1; go to FETCH.
- WB: reg_we=1 for exactly one cycle; instr_done=1; go to FETCH.
- mem_req is never deasserted before ack (except by reset). mem_addr and mem_we are stable while mem_req=1.
- Latency with zero-wait ack:
  - ALU op: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch or no-op: 3 cycles.

Optional Feature:
- Macro: CPU_SEQ_SINGLE_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - FETCH issues mem_req only when run=1 or when a step rising edge is seen.
  - A step edge is latched until the fetch is accepted, so exactly one instruction executes per edge while run=0.
- When undefined: no step port; FETCH is gated by run only.

Decomposition:
- Package cpu_pkg:
  - state enum localparams (ST_FETCH=0, ST_DECODE=1, ST_EXEC=2, ST_MEM=3, ST_WB=4).
  - PC_W/DATA_W defaults.
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_AND=2, OP_BR=3, OP_LD=4, OP_ST=5, OP_LDC=6, OP_LDH=7.
- One sub-module: cpu_pc_reg. It holds the PC register with inc/load enables and wrap, and the reset value 0.

Test Plan:
- Reset, run=1, memory[0]=8'h00 (ADD) with zero-wait ack, expected strobes dec_w_reg=1 only → pc=1, reg_we pulses on cycle 4, instr_done on cycle 4.
- Fetch ack delayed 3 cycles → mem_req and mem_addr=0 held steady throughout; ir updates only on the ack cycle.
- Branch with dec_branch=1, br_take=1, br_target=8'h40 → pc=8'h40 after EXEC; next mem_addr=8'h40. With br_take=0 → pc=1.
- Load with data_addr=8'h80 and mem_rdata=8'hA5 on ack → mdr=8'hA5, reg_we one cycle later. Store → mem_we=1, mem_addr=8'h80, no reg_we.
- pc=8'hFF, fetch ack → pc wraps to 8'h00. Reset asserted during MEM wait → state=FETCH and mem_req=0 immediately; a late ack is ignored.
- run=0 → no mem_req for 10 cycles. Under CPU_SEQ_SINGLE_STEP_EN, two step pulses → exactly two instr_done pulses.
